// File: rtl/cache_stat_counter.sv
// Cache access statistics: nine saturating event counters fed by a per-cycle
// access report, with a RUN -> DRAIN -> DONE sequencer that freezes results.
module cache_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             acc_valid,
  input  logic             acc_icache,
  input  logic             acc_write,
  input  logic             acc_hit,
  input  logic             trace_end,
  output logic [CNT_W-1:0] DC_Reads,
  output logic [CNT_W-1:0] DC_Read_Hit,
  output logic [CNT_W-1:0] DC_Read_Miss,
  output logic [CNT_W-1:0] DC_Writes,
  output logic [CNT_W-1:0] DC_Write_Hit,
  output logic [CNT_W-1:0] DC_Write_Miss,
  output logic [CNT_W-1:0] IC_Reads,
  output logic [CNT_W-1:0] IC_Read_Hit,
  output logic [CNT_W-1:0] IC_Read_Miss,
  output logic             done,
  output logic             err_ic_write
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [8:0]       inc;
  logic [CNT_W-1:0] cnt [9];
  logic             run_acc;

  assign run_acc = (state == S_RUN) && acc_valid;

  // Counter order: DC rd/hit/miss, DC wr/hit/miss, IC rd/hit/miss.
  always_comb begin
    inc = '0;
    if (run_acc) begin
      if (!acc_icache && !acc_write) begin
        inc[0] = 1'b1;
        inc[acc_hit ? 1 : 2] = 1'b1;
      end else if (!acc_icache && acc_write) begin
        inc[3] = 1'b1;
        inc[acc_hit ? 4 : 5] = 1'b1;
      end else if (acc_icache && !acc_write) begin
        inc[6] = 1'b1;
        inc[acc_hit ? 7 : 8] = 1'b1;
      end
    end
  end

  // Each counter saturates independently so a stuck total never blocks its hit/miss partner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 9; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (inc[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_ic_write <= 1'b0;
    else if (clear)
      err_ic_write <= 1'b0;
    else if (run_acc && acc_icache && acc_write)
      err_ic_write <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else if (clear) begin
      state <= S_RUN;
    end else begin
      case (state)
        S_RUN:   if (trace_end) state <= S_DRAIN;
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_DONE;
        default: state <= S_RUN;
      endcase
    end
  end

  assign done = (state == S_DONE);

  assign DC_Reads      = cnt[0];
  assign DC_Read_Hit   = cnt[1];
  assign DC_Read_Miss  = cnt[2];
  assign DC_Writes     = cnt[3];
  assign DC_Write_Hit  = cnt[4];
  assign DC_Write_Miss = cnt[5];
  assign IC_Reads      = cnt[6];
  assign IC_Read_Hit   = cnt[7];
  assign IC_Read_Miss  = cnt[8];

endmodule
